branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Registered EX-stage control-flow resolver; successor to the combinational jump/branch calculator.
//  Resolves JAL/JALR/BRANCH outcome and target, compares against the fetch prediction and flags a redirect.
//  Owns a parametrised 2-bit branch history table (BHT) that fetch reads and that resolved branches train.
//  Sits between decode/EX operands and the fetch redirect path, with a valid/ready handshake on both sides.
// PARAMETERS
//  ADDR_WIDTH     32  width of pc/imm/rs1/rs2/targets; >= BHT_IDX_BITS+2
//  BHT_IDX_BITS   6   BHT has 2**BHT_IDX_BITS entries, indexed by pc[BHT_IDX_BITS+1:2]
//  PERF_CNT_WIDTH 32  width of performance counters (used only with BRU_PERF_EN)
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           asynchronous reset, active-high
//  flush           in   1           drop the held result and block acceptance this cycle
//  in_valid        in   1           operand bundle valid
//  in_ready        out  1           = !out_valid | out_ready
//  opcode          in   7           instruction opcode
//  funct3          in   3           branch condition select
//  pc, imm         in   ADDR_WIDTH  instruction pc; sign-extended immediate
//  rs1, rs2        in   ADDR_WIDTH  register operands
//  pred_taken      in   1           fetch prediction: taken
//  pred_target     in   ADDR_WIDTH  fetch prediction: target
//  out_valid       out  1           result register valid
//  out_ready       in   1           consumer accepts result
//  taken           out  1           actual outcome
//  redirect        out  1           misprediction; fetch restarts at redirect_addr
//  redirect_addr   out  ADDR_WIDTH  taken ? target : pc+4
//  link_addr       out  ADDR_WIDTH  pc+4 (JAL/JALR rd value)
//  misaligned      out  1           taken and target[1]==1
//  lookup_pc       in   ADDR_WIDTH  fetch BHT query pc
//  lookup_taken    out  1           combinational: BHT[idx(lookup_pc)][1]
// BEHAVIOUR
//  Reset: out_valid=0; taken/redirect/misaligned=0; redirect_addr/link_addr=0; every BHT entry=2'b01.
//  Accept when in_valid & in_ready & !flush; result registered next edge (latency 1).
//  Hold: out_valid & !out_ready keeps all outputs stable; no new acceptance.
//  flush: out_valid<=0 next edge; nothing accepted that cycle and the BHT is not trained.
//  Target: JAL/BRANCH pc+imm; JALR (rs1+imm)&~1. All arithmetic is modulo 2**ADDR_WIDTH.
//  Taken: JAL/JALR always. BRANCH per funct3: BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU (unsigned).
//  Undefined funct3 (010/011) is not taken. Any other opcode is not taken.
//  redirect = (taken != pred_taken) | (taken & pred_target != target).
//  Non-control-flow opcode with pred_taken=1: redirect=1, redirect_addr=pc+4.
//  misaligned is reported alongside redirect; redirect is not suppressed (trap logic decides).
//  BHT training: only on an accepted BRANCH; counter saturates at 00 and 11 (+1 taken, -1 not).
//  Same-cycle lookup and train of one index: lookup returns the pre-update value.
//  Trains are one per cycle; back-to-back trains of one index accumulate correctly.
// CONFIGURATION
//  BRU_PERF_EN defined adds out ports perf_branches and perf_mispredicts [PERF_CNT_WIDTH].
//  Each counter increments on acceptance of a BRANCH (and, for mispredicts, when that result has
//  redirect=1), wraps at 2**PERF_CNT_WIDTH and resets to 0.
//  BRU_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package bru_pkg: OPCODE_JAL/JALR/BRANCH, FUNCT3_BEQ..BGEU,
//  and 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11.
//  Sub-module bht_2bit (counter array, async reset, one read port, one train port).
//  Resolve logic and the output register stay in the top module.
// TESTING
//  BEQ pc=0x100 imm=0x20 rs1=rs2=5 pred_taken=0 -> taken=1, redirect=1, redirect_addr=0x120, BHT[0]=10.
//  JALR rs1=0x1001 imm=0x4 pred_taken=1 pred_target=0x1004 -> target 0x1004, redirect=0, link=pc+4.
//  BLT rs1=0xFFFFFFFF rs2=1 -> taken=1; BLTU with same operands -> taken=0.
//  Train one index taken 4x then lookup -> 11 held; 4 not-taken -> 00 held; same-cycle lookup returns old value.
//  out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; flush then -> out_valid=0, BHT unchanged.
//  rst asserted mid-stream -> out_valid=0 immediately and all BHT entries=01; BRU_PERF_EN counters=0.

Source files
------------

// File: rtl/bru_pkg.sv
// bru_pkg: opcodes, branch conditions and 2-bit BHT counter encodings shared by the branch resolve unit.
package bru_pkg;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;
  function automatic ctr_t ctr_next(input ctr_t c, input logic t);
    return t ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: array of saturating 2-bit counters with one combinational read port and one train port.
module bht_2bit import bru_pkg::*; #(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] lookup_idx,
  output logic [1:0]          lookup_ctr,
  input  logic                train,
  input  logic [IDX_BITS-1:0] train_idx,
  input  logic                train_taken
);
  ctr_t ctr [2**IDX_BITS];
  // Read is before the edge, so a same-cycle train is invisible to lookup.
  assign lookup_ctr = ctr[lookup_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2**IDX_BITS; i++) ctr[i] <= WNT;
    else if (train) ctr[train_idx] <= ctr_next(ctr[train_idx], train_taken);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered JAL/JALR/BRANCH resolver with misprediction redirect and 2-bit BHT.
// Optional BRU_PERF_EN adds branch and mispredict counters.
module branch_resolve_unit import bru_pkg::*; #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BHT_IDX_BITS   = 6,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] imm,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  pred_taken,
  input  logic [ADDR_WIDTH-1:0] pred_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  taken,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] link_addr,
  output logic                  misaligned,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_taken
`ifdef BRU_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_branches,
  output logic [PERF_CNT_WIDTH-1:0] perf_mispredicts
`endif
);
  logic is_jal, is_jalr, is_br, eq, lt, ltu, br_taken, taken_c, redirect_c, accept;
  logic [ADDR_WIDTH-1:0] pc_sum, rs_sum, target, link;
  logic [1:0] lookup_ctr;
  logic unused_bits;
  assign is_jal     = opcode == OPCODE_JAL;
  assign is_jalr    = opcode == OPCODE_JALR;
  assign is_br      = opcode == OPCODE_BRANCH;
  assign pc_sum     = pc + imm;
  assign rs_sum     = rs1 + imm;
  assign target     = is_jalr ? {rs_sum[ADDR_WIDTH-1:1], 1'b0} : pc_sum;
  assign link       = pc + ADDR_WIDTH'(4);
  assign eq         = rs1 == rs2;
  assign lt         = $signed(rs1) < $signed(rs2);
  assign ltu        = rs1 < rs2;
  assign br_taken   = funct3 == FUNCT3_BEQ  ? eq   :
                      funct3 == FUNCT3_BNE  ? !eq  :
                      funct3 == FUNCT3_BLT  ? lt   :
                      funct3 == FUNCT3_BGE  ? !lt  :
                      funct3 == FUNCT3_BLTU ? ltu  :
                      funct3 == FUNCT3_BGEU ? !ltu : 1'b0;
  assign taken_c    = is_jal | is_jalr | (is_br & br_taken);
  assign redirect_c = (taken_c != pred_taken) | (taken_c & (pred_target != target));
  assign in_ready   = !out_valid | out_ready;
  assign accept     = in_valid & in_ready & !flush;
  assign unused_bits = ^{lookup_pc, lookup_ctr[0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid     <= 1'b0;
      taken         <= 1'b0;
      redirect      <= 1'b0;
      misaligned    <= 1'b0;
      redirect_addr <= '0;
      link_addr     <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : in_ready ? accept : out_valid;
      if (accept) begin
        taken         <= taken_c;
        redirect      <= redirect_c;
        misaligned    <= taken_c & target[1];
        redirect_addr <= taken_c ? target : link;
        link_addr     <= link;
      end
    end
  bht_2bit #(.IDX_BITS(BHT_IDX_BITS)) u_bht (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (lookup_pc[BHT_IDX_BITS+1:2]),
    .lookup_ctr (lookup_ctr),
    .train      (accept & is_br),
    .train_idx  (pc[BHT_IDX_BITS+1:2]),
    .train_taken(taken_c)
  );
  assign lookup_taken = lookup_ctr[1];
`ifdef BRU_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (accept & is_br) begin
      perf_branches <= perf_branches + 1'b1;
      if (redirect_c) perf_mispredicts <= perf_mispredicts + 1'b1;
    end
`else
  localparam int unused_perf_w = PERF_CNT_WIDTH;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus hand-written hold, flush, BHT and reset sequences.
module tb_branch_resolve_unit;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, ALU = 7'b0110011;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] pc = 0, imm = 0, rs1 = 0, rs2 = 0, pred_target = 0, lookup_pc = 0;
  logic pred_taken = 0, taken, redirect, misaligned, lookup_taken;
  logic [31:0] redirect_addr, link_addr;
`ifdef BRU_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
    .pred_taken(pred_taken), .pred_target(pred_target), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .redirect(redirect), .redirect_addr(redirect_addr),
    .link_addr(link_addr), .misaligned(misaligned), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
`ifdef BRU_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [31:0] pc, imm, rs1, rs2; logic pt; logic [31:0] ptgt;
    logic tk, rd; logic [31:0] ra, la; logic mis;
  } vec_t;
  vec_t v [14];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p, i, a, b,
                              input logic pt, input logic [31:0] ptgt, input logic tk, rd,
                              input logic [31:0] ra, la, input logic mis);
    vec_t r;
    r.op = op; r.f3 = f3; r.pc = p; r.imm = i; r.rs1 = a; r.rs2 = b; r.pt = pt; r.ptgt = ptgt;
    r.tk = tk; r.rd = rd; r.ra = ra; r.la = la; r.mis = mis;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    opcode = x.op; funct3 = x.f3; pc = x.pc; imm = x.imm; rs1 = x.rs1; rs2 = x.rs2;
    pred_taken = x.pt; pred_target = x.ptgt;
  endtask

  task automatic check_out(input string nm, input vec_t x);
    check({nm, ".valid"}, out_valid, 1);
    check({nm, ".taken"}, taken, x.tk);
    check({nm, ".redirect"}, redirect, x.rd);
    check({nm, ".raddr"}, redirect_addr, x.ra);
    check({nm, ".link"}, link_addr, x.la);
    check({nm, ".mis"}, misaligned, x.mis);
  endtask

  task automatic train(input logic [31:0] p, input logic tk);
    @(negedge clk);
    opcode = BR; funct3 = 3'b000; pc = p; imm = 32'h10; rs1 = 0; rs2 = tk ? 0 : 1;
    pred_taken = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic lookup(input string nm, input logic [31:0] p, input logic exp);
    lookup_pc = p; #1 check(nm, lookup_taken, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; #2 rst = 0;
  endtask

  initial begin
    v[0]  = mk(BR,   3'b000, 32'h100, 32'h20, 5, 5, 0, 0, 1, 1, 32'h120, 32'h104, 0);
    v[1]  = mk(JALR, 3'b000, 32'h204, 32'h4, 32'h1001, 0, 1, 32'h1004, 1, 0, 32'h1004, 32'h208, 0);
    v[2]  = mk(BR,   3'b100, 32'h308, 32'h40, 32'hFFFFFFFF, 1, 1, 32'h348, 1, 0, 32'h348, 32'h30C, 0);
    v[3]  = mk(BR,   3'b110, 32'h30C, 32'h40, 32'hFFFFFFFF, 1, 1, 32'h34C, 0, 1, 32'h310, 32'h310, 0);
    v[4]  = mk(BR,   3'b001, 32'h410, 32'hFFFFFFF8, 1, 2, 1, 32'h3F0, 1, 1, 32'h408, 32'h414, 0);
    v[5]  = mk(BR,   3'b101, 32'h514, 32'h10, 1, 32'hFFFFFFFF, 0, 0, 1, 1, 32'h524, 32'h518, 0);
    v[6]  = mk(BR,   3'b111, 32'h518, 32'h10, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h51C, 32'h51C, 0);
    v[7]  = mk(BR,   3'b010, 32'h61C, 32'h10, 7, 7, 0, 0, 0, 0, 32'h620, 32'h620, 0);
    v[8]  = mk(ALU,  3'b000, 32'h720, 32'h10, 0, 0, 1, 32'h999, 0, 1, 32'h724, 32'h724, 0);
    v[9]  = mk(JAL,  3'b000, 32'h824, 32'h102, 0, 0, 0, 0, 1, 1, 32'h926, 32'h828, 1);
    v[10] = mk(JAL,  3'b000, 32'hFFFFFFFC, 32'h8, 0, 0, 1, 32'h4, 1, 0, 32'h4, 32'h0, 0);
    v[11] = mk(JALR, 3'b000, 32'h900, 32'h7, 32'h2000, 0, 1, 32'h2006, 1, 0, 32'h2006, 32'h904, 1);
    v[12] = mk(BR,   3'b000, 32'hA28, 32'h10, 3, 4, 0, 0, 0, 0, 32'hA2C, 32'hA2C, 0);
    v[13] = mk(BR,   3'b000, 32'hB2C, 32'h20, 9, 9, 1, 32'hB50, 1, 1, 32'hB4C, 32'hB30, 0);
    #12 rst = 0;
    @(negedge clk);
    check("rst.valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.outs", {taken, redirect, misaligned, redirect_addr, link_addr}, 0);
    lookup("rst.bht0", 32'h100, 0);
    lookup("rst.bht3f", 32'hFC, 0);
`ifdef BRU_PERF_EN
    check("rst.perf", {perf_branches, perf_mispredicts}, 0);
`endif
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); drive(v[i]); in_valid = 1;
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk); check_out($sformatf("vec%0d", i), v[i]);
    end
    lookup("bht.beq_taken", 32'h100, 1);
    lookup("bht.blt_taken", 32'h308, 1);
    lookup("bht.bltu_nt", 32'h30C, 0);
    train(32'h100, 0);
    lookup("bht.beq_10_to_01", 32'h100, 0);
`ifdef BRU_PERF_EN
    check("perf.branches", perf_branches, 10);
    check("perf.mispredicts", perf_mispredicts, 5);
`endif
    // Saturation and back-to-back accumulation on one index
    do_reset();
    for (int i = 0; i < 4; i++) train(32'h40, 1);
    lookup("sat.st", 32'h40, 1);
    train(32'h40, 0);
    lookup("sat.st_minus1", 32'h40, 1);
    for (int i = 0; i < 4; i++) train(32'h40, 0);
    lookup("sat.snt", 32'h40, 0);
    train(32'h40, 1);
    lookup("sat.snt_plus1", 32'h40, 0);
    train(32'h40, 1);
    lookup("sat.snt_plus2", 32'h40, 1);
    // Same-cycle lookup and train
    @(negedge clk);
    opcode = BR; funct3 = 3'b000; pc = 32'h80; rs1 = 0; rs2 = 0; in_valid = 1;
    lookup("samecyc.old", 32'h80, 0);
    @(posedge clk); #1 in_valid = 0;
    check("samecyc.new", lookup_taken, 1);
    // Hold under backpressure, then flush
    do_reset();
    @(negedge clk); drive(v[0]); in_valid = 1; out_ready = 0;
    @(posedge clk); #1 drive(v[2]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d.in_ready", i), in_ready, 0);
      check_out($sformatf("hold%0d", i), v[0]);
    end
    lookup("hold.no_train", 32'h308, 0);
    flush = 1;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush.valid", out_valid, 0);
    out_ready = 1; drive(v[2]); in_valid = 1; flush = 1;
    #1 check("flush.in_ready", in_ready, 1);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush2.valid", out_valid, 0);
    lookup("flush.bht_kept", 32'h308, 0);
    lookup("flush.bht_beq", 32'h100, 1);
    // Asynchronous reset mid-stream
    train(32'h40, 1);
    train(32'h40, 1);
    check("midrst.pre_valid", out_valid, 1);
    lookup_pc = 32'h40; #1 check("midrst.pre_bht", lookup_taken, 1);
    rst = 1; #1;
    check("midrst.valid", out_valid, 0);
    check("midrst.outs", {taken, redirect, misaligned, redirect_addr, link_addr}, 0);
    check("midrst.bht", lookup_taken, 0);
`ifdef BRU_PERF_EN
    check("midrst.perf", {perf_branches, perf_mispredicts}, 0);
`endif
    #1 rst = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
